// File: rtl/core_out_arbiter_if.sv
// -----------------------------------------------------------------------------
// core_out_arbiter_if
// Bundles the two data paths of the core output arbiter:
//   source side : in_dout / in_empty (from the per-core FWFT sources),
//                 in_rd_en (per-channel pop strobe back to the sources)
//   sink side   : dout / out_empty / out_count (output FIFO head and state),
//                 out_rd_en (pop strobe from the downstream consumer)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (sources plus downstream consumer)
// -----------------------------------------------------------------------------
interface core_out_arbiter_if #(
    parameter int N_CORES    = 16,
    parameter int DOUT_WIDTH = 4,
    parameter int OUT_DEPTH  = 16,
    parameter int ID_WIDTH   = 5
);
    localparam int ENTRY_W = ID_WIDTH + 1 + DOUT_WIDTH;
    localparam int CNT_W   = $clog2(OUT_DEPTH) + 1;

    logic [N_CORES*DOUT_WIDTH-1:0] in_dout;
    logic [N_CORES-1:0]            in_empty;
    logic [N_CORES-1:0]            in_rd_en;
    logic [ENTRY_W-1:0]            dout;
    logic                          out_empty;
    logic                          out_rd_en;
    logic [CNT_W-1:0]              out_count;

    modport slave (
        input  in_dout, in_empty, out_rd_en,
        output in_rd_en, dout, out_empty, out_count
    );

    modport master (
        output in_dout, in_empty, out_rd_en,
        input  in_rd_en, dout, out_empty, out_count
    );
endinterface

// File: rtl/core_out_arbiter.sv
// -----------------------------------------------------------------------------
// core_out_arbiter
// Round-robin packet arbiter that gathers fixed-length result packets from
// N_CORES first-word-fall-through sources into one FWFT output FIFO. Each
// FIFO entry is {channel id, last flag, data word}. A packet whose source
// runs dry for STALL_LIMIT cycles is abandoned and flagged in err_stall.
// Ports:
//   CLK, RST_N - clock and asynchronous active-low reset
//   bus        - source side (in_dout, in_empty, in_rd_en) and output FIFO
//                side (dout, out_empty, out_rd_en, out_count)
//   chan_en    - per-channel arbitration enable (sampled only when granting)
//   err_clr    - clears all sticky err_stall bits (a same-cycle set wins)
//   err_stall  - sticky per-channel packet-abort flags
// -----------------------------------------------------------------------------
module core_out_arbiter #(
    parameter int N_CORES     = 16,
    parameter int DOUT_WIDTH  = 4,
    parameter int PKT_WORDS   = 8,
    parameter int OUT_DEPTH   = 16,
    parameter int STALL_LIMIT = 15,
    parameter int ID_WIDTH    = 5
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    core_out_arbiter_if.slave    bus,
    input  logic [N_CORES-1:0]   chan_en,
    input  logic                 err_clr,
    output logic [N_CORES-1:0]   err_stall
);

    localparam int ENTRY_W = ID_WIDTH + 1 + DOUT_WIDTH;
    localparam int AW      = $clog2(OUT_DEPTH);
    localparam int CNT_W   = AW + 1;
    localparam int WC_W    = $clog2(PKT_WORDS);
    localparam int SC_W    = $clog2(STALL_LIMIT + 1);

    localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(OUT_DEPTH);
    localparam logic [WC_W-1:0]     LAST_WORD = WC_W'(PKT_WORDS - 1);
    localparam logic [SC_W-1:0]     STALL_HIT = SC_W'(STALL_LIMIT - 1);
    localparam logic [ID_WIDTH-1:0] PTR_RST   = ID_WIDTH'(N_CORES - 1);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   g_q, g_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [WC_W-1:0]       word_cnt_q, word_cnt_d;
    logic [SC_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [N_CORES-1:0]    err_q, err_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ENTRY_W-1:0]    mem_q [OUT_DEPTH];

    // ---------------------------------------------------------------- arbiter
    // Round-robin pick: the lowest eligible channel above ptr wins; if none is
    // above ptr, wrap to the lowest eligible channel overall.
    logic [N_CORES-1:0]  elig;
    logic                hi_found;
    logic [ID_WIDTH-1:0] hi_idx, lo_idx;
    logic                sel_found;
    logic [ID_WIDTH-1:0] sel_idx;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        elig     = chan_en & ~bus.in_empty;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_idx = ID_WIDTH'(i);
                if (ID_WIDTH'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_WIDTH'(i);
                end
            end
        end
        sel_found = |elig;
        sel_idx   = hi_found ? hi_idx : lo_idx;
    end

    // ------------------------------------------------- granted-channel muxing
    logic [N_CORES-1:0]    g_onehot;
    logic                  cur_empty;
    logic [DOUT_WIDTH-1:0] cur_data;

    always_comb begin
        g_onehot  = '0;
        cur_empty = 1'b1;
        cur_data  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (g_q == ID_WIDTH'(i)) begin
                g_onehot[i] = 1'b1;
                cur_empty   = bus.in_empty[i];
                cur_data    = bus.in_dout[i*DOUT_WIDTH +: DOUT_WIDTH];
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never
    // opens room for a push.
    logic full, pop_src, is_last, pop_out;

    assign full    = (count_q == FULL_CNT);
    assign pop_src = (state_q == XFER) && !cur_empty && !full;
    assign is_last = (word_cnt_q == LAST_WORD);
    assign pop_out = bus.out_rd_en && (count_q != '0);

    assign bus.in_rd_en = pop_src ? g_onehot : '0;

    // ------------------------------------------------------------- controller
    logic [N_CORES-1:0] err_set;

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        word_cnt_d  = word_cnt_q;
        stall_cnt_d = stall_cnt_q;
        err_set     = '0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d     = XFER;
                    g_d         = sel_idx;
                    word_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            XFER: begin
                if (pop_src) begin
                    stall_cnt_d = '0;
                    word_cnt_d  = word_cnt_q + 1'b1;
                    if (is_last) begin
                        state_d    = IDLE;
                        ptr_d      = g_q;
                        word_cnt_d = '0;
                    end
                end else if (cur_empty && !full) begin
                    // Starved source: count toward the abort; a full output
                    // FIFO is back-pressure, not starvation, so it holds.
                    if (stall_cnt_q == STALL_HIT) begin
                        err_set     = g_onehot;
                        state_d     = IDLE;
                        ptr_d       = g_q;
                        stall_cnt_d = '0;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Set is applied after clear so a coincident set wins.
    assign err_d     = (err_q & ~{N_CORES{err_clr}}) | err_set;
    assign err_stall = err_q;

    // ------------------------------------------------------------ output FIFO
    always_comb begin
        wr_ptr_d = pop_src ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_out ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({pop_src, pop_out})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign bus.dout      = mem_q[rd_ptr_q];
    assign bus.out_empty = (count_q == '0);
    assign bus.out_count = count_q;

    // ------------------------------------------------------------- registers
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!RST_N) begin
            state_q     <= IDLE;
            g_q         <= '0;
            ptr_q       <= PTR_RST;
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count are reset,
    // so stale contents are never presented as valid data.
    always_ff @(posedge CLK) begin
        if (pop_src) begin
            mem_q[wr_ptr_q] <= {g_q, is_last, cur_data};
        end
    end

endmodule

// File: tb/tb_core_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_out_arbiter
// Self-checking bench for core_out_arbiter (4 channels, 8-word packets,
// 16-entry output FIFO, stall limit 15). Sources are bench-side queues; a
// packet-level model with a queue for the output FIFO predicts in_rd_en,
// FIFO state and err_stall every cycle, and directed scenarios pin the
// model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_core_out_arbiter;
    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int PKT   = 8;
    localparam int DEPTH = 16;
    localparam int LIMIT = 15;
    localparam int IDW   = 5;
    localparam int EW    = IDW + 1 + DW;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b0;
    logic [N-1:0]  chan_en;
    logic          err_clr;
    logic [N-1:0]  err_stall;

    core_out_arbiter_if #(.N_CORES(N), .DOUT_WIDTH(DW), .OUT_DEPTH(DEPTH), .ID_WIDTH(IDW)) bus ();

    core_out_arbiter #(
        .N_CORES(N), .DOUT_WIDTH(DW), .PKT_WORDS(PKT),
        .OUT_DEPTH(DEPTH), .STALL_LIMIT(LIMIT), .ID_WIDTH(IDW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .chan_en   (chan_en),
        .err_clr   (err_clr),
        .err_stall (err_stall)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- sources
    logic [DW-1:0] src [N][$];
    logic [N-1:0]  rd_samp = '0;

    task automatic drive_src();
        for (int c = 0; c < N; c++) begin
            bus.in_empty[c] = (src[c].size() == 0);
            bus.in_dout[c*DW +: DW] = (src[c].size() != 0) ? src[c][0] : '0;
        end
    endtask

    task automatic load(input int c, input int n, input int base);
        for (int k = 0; k < n; k++) src[c].push_back(DW'(base + k));
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RST_N) begin
                for (int c = 0; c < N; c++)
                    if (rd_samp[c] && src[c].size() != 0) void'(src[c].pop_front());
            end
            drive_src();
        end
    end

    // --------------------------------------------------------------- model
    logic [EW-1:0] m_fifo[$];
    bit            m_busy, m_full, m_do_pop, m_found;
    int            m_cur, m_words, m_stall, m_rr, m_c;
    logic [N-1:0]  m_err, m_exp_rd;

    task automatic model_reset();
        m_fifo.delete();
        m_busy  = 1'b0;
        m_cur   = 0;
        m_words = 0;
        m_stall = 0;
        m_rr    = N - 1;
        m_err   = '0;
    endtask

    // Logs of what the DUT did, used by the directed literal checks.
    int            cyc = 0;
    int            err_rise_cyc = -1;
    int            pop_ch[$];
    int            pop_cyc[$];
    logic [EW-1:0] drained[$];

    task automatic clear_logs();
        pop_ch.delete();
        pop_cyc.delete();
        drained.delete();
        err_rise_cyc = -1;
    endtask

    // Compare and advance on the falling edge: inputs are stable here and
    // describe exactly what the DUT will act on at the next rising edge.
    always @(negedge CLK) begin
        cyc++;
        if (!RST_N) begin
            model_reset();
            rd_samp = '0;
        end else begin
            m_full   = (m_fifo.size() >= DEPTH);
            m_do_pop = m_busy && (src[m_cur].size() != 0) && !m_full;
            m_exp_rd = '0;
            if (m_do_pop) m_exp_rd[m_cur] = 1'b1;

            check("in_rd_en",  bus.in_rd_en,  m_exp_rd);
            check("out_empty", bus.out_empty, m_fifo.size() == 0);
            check("out_count", bus.out_count, m_fifo.size());
            check("err_stall", err_stall,     m_err);
            if (m_fifo.size() != 0) check("dout", bus.dout, m_fifo[0]);

            rd_samp = bus.in_rd_en;
            for (int c = 0; c < N; c++)
                if (bus.in_rd_en[c]) begin
                    pop_ch.push_back(c);
                    pop_cyc.push_back(cyc);
                end
            if (bus.out_rd_en && !bus.out_empty) drained.push_back(bus.dout);
            if (err_stall != 0 && err_rise_cyc < 0) err_rise_cyc = cyc;

            if (bus.out_rd_en && m_fifo.size() != 0) void'(m_fifo.pop_front());
            if (err_clr) m_err = '0;
            if (!m_busy) begin
                m_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    m_c = (m_rr + k) % N;
                    if (!m_found && chan_en[m_c] && src[m_c].size() != 0) begin
                        m_found = 1'b1;
                        m_busy  = 1'b1;
                        m_cur   = m_c;
                        m_words = 0;
                        m_stall = 0;
                    end
                end
            end else if (m_do_pop) begin
                m_fifo.push_back({IDW'(m_cur), (m_words == PKT - 1), src[m_cur][0]});
                m_stall = 0;
                if (m_words == PKT - 1) begin
                    m_busy = 1'b0;
                    m_rr   = m_cur;
                end else begin
                    m_words++;
                end
            end else if (src[m_cur].size() == 0 && !m_full) begin
                m_stall++;
                if (m_stall == LIMIT) begin
                    m_err[m_cur] = 1'b1;
                    m_busy       = 1'b0;
                    m_rr         = m_cur;
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic do_reset();
        RST_N         = 1'b0;
        bus.out_rd_en = 1'b0;
        err_clr       = 1'b0;
        chan_en       = '1;
        for (int c = 0; c < N; c++) src[c].delete();
        drive_src();
        step(2);
        check("rst_out_empty", bus.out_empty, 1);
        check("rst_out_count", bus.out_count, 0);
        check("rst_err_stall", err_stall, 0);
        check("rst_in_rd_en",  bus.in_rd_en, 0);
        RST_N = 1'b1;
        clear_logs();
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int t = 0;
        while (pop_ch.size() < n && t < budget) begin
            step();
            t++;
        end
        check(name, pop_ch.size() >= n, 1);
    endtask

    task automatic wait_drained(input int n, input int budget, input string name);
        int t = 0;
        while (drained.size() < n && t < budget) begin
            step();
            t++;
        end
        check(name, drained.size() >= n, 1);
    endtask

    // Ids of completed packets, in the order their last words left the FIFO.
    task automatic grant_seq_check(input string name, input int exp_seq[5], input int n);
        int idx = 0;
        for (int i = 0; i < drained.size(); i++) begin
            if (drained[i][DW] && idx < n) begin
                check($sformatf("%s_%0d", name, idx), drained[i][EW-1:DW+1], exp_seq[idx]);
                idx++;
            end
        end
        check($sformatf("%s_count", name), idx, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        bus.out_rd_en = 1'b0;
        err_clr       = 1'b0;
        chan_en       = '1;
        model_reset();
        drive_src();

        // Two single-packet channels, channel 0 drops its enable mid-packet.
        do_reset();
        load(0, 8, 0);
        load(2, 8, 8);
        drive_src();
        bus.out_rd_en = 1'b1;
        wait_pops(3, 20, "r035_start");
        chan_en[0] = 1'b0;
        wait_drained(16, 80, "r035_wait");
        step(5);
        check("r035_words", drained.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < drained.size())
                check($sformatf("r035_word%0d", i), drained[i],
                      {IDW'(i < 8 ? 0 : 2), (i == 7 || i == 15), DW'(i)});
        if (pop_cyc.size() >= 9) begin
            check("r035_burst", pop_cyc[7] - pop_cyc[0], 7);
            check("r035_gap",   pop_cyc[8] - pop_cyc[7], 2);
        end

        // All channels always ready: plain round robin, then with channel 1 off.
        do_reset();
        for (int c = 0; c < N; c++) load(c, 40, c * 3);
        drive_src();
        bus.out_rd_en = 1'b1;
        step(60);
        grant_seq_check("r036_rr", '{0, 1, 2, 3, 0}, 5);

        do_reset();
        for (int c = 0; c < N; c++) load(c, 40, c * 3);
        drive_src();
        chan_en[1]    = 1'b0;
        bus.out_rd_en = 1'b1;
        step(60);
        grant_seq_check("r036_skip", '{0, 2, 3, 0, 2}, 5);

        // Output FIFO back-pressure.
        do_reset();
        for (int c = 0; c < N; c++) load(c, 40, c);
        drive_src();
        step(50);
        check("r037_pops",   pop_ch.size(), 16);
        check("r037_rd_en",  bus.in_rd_en, 0);
        check("r037_count",  bus.out_count, 16);
        bus.out_rd_en = 1'b1;
        step();
        bus.out_rd_en = 1'b0;
        step(10);
        check("r037_pops2",  pop_ch.size(), 17);
        check("r037_count2", bus.out_count, 16);
        if (pop_ch.size() > 16) check("r037_ch", pop_ch[16], 2);
        check("r037_err",    err_stall, 0);

        // Channel 3 starves after 3 words.
        do_reset();
        load(3, 3, 5);
        drive_src();
        step(40);
        check("r038_err",   err_stall, 4'b1000);
        check("r038_count", bus.out_count, 3);
        check("r038_pops",  pop_ch.size(), 3);
        if (pop_cyc.size() >= 3) check("r038_timing", err_rise_cyc - pop_cyc[2], 16);
        load(1, 8, 0);
        drive_src();
        step(4);
        if (pop_ch.size() > 3) check("r038_regrant", pop_ch[3], 1);
        else check("r038_regrant_seen", pop_ch.size(), 4);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        check("r038_clr", err_stall, 0);
        bus.out_rd_en = 1'b1;
        wait_drained(3, 20, "r038_drain");
        for (int i = 0; i < 3; i++)
            if (i < drained.size())
                check($sformatf("r038_word%0d", i), drained[i], {IDW'(3), 1'b0, DW'(5 + i)});

        // Reset pulse in the middle of channel 1's packet.
        do_reset();
        load(0, 16, 0);
        load(1, 8, 3);
        drive_src();
        bus.out_rd_en = 1'b1;
        wait_pops(11, 60, "r039_mid");
        RST_N = 1'b0;
        step();
        check("r039_empty", bus.out_empty, 1);
        check("r039_count", bus.out_count, 0);
        check("r039_err",   err_stall, 0);
        check("r039_rd_en", bus.in_rd_en, 0);
        RST_N = 1'b1;
        clear_logs();
        wait_pops(1, 10, "r039_regrant_wait");
        if (pop_ch.size() > 0) check("r039_regrant", pop_ch[0], 0);

        // Simultaneous push and pop at out_count = 5.
        do_reset();
        load(0, 8, 0);
        drive_src();
        t = 0;
        while (bus.out_count != 5 && t < 20) begin
            step();
            t++;
        end
        check("r040_reach5", bus.out_count, 5);
        bus.out_rd_en = 1'b1;
        step();
        check("r040_hold", bus.out_count, 5);
        wait_drained(8, 30, "r040_drain");
        for (int i = 0; i < 8; i++)
            if (i < drained.size())
                check($sformatf("r040_word%0d", i), drained[i], {IDW'(0), (i == 7), DW'(i)});

        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
